// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg -- shared definitions for the AES frame scheduler.
// Holds the scheduler state encoding, command and error codes, the bit
// ranges of the received I2C frame, and a small error-priority helper.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    localparam logic [7:0] CMD_ENC = 8'h01;
    localparam logic [7:0] CMD_DEC = 8'h02;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int unsigned FRAME_W = 264;
    localparam int unsigned CMD_HI  = 263;
    localparam int unsigned CMD_LO  = 256;
    localparam int unsigned KEY_HI  = 255;
    localparam int unsigned KEY_LO  = 128;
    localparam int unsigned DATA_HI = 127;
    localparam int unsigned DATA_LO = 0;

    // Errors raised in the same cycle resolve to the higher code.
    function automatic logic [1:0] err_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog -- cycle counter bounding how long the scheduler waits
// for the AES core. Only instantiated when FRAME_TIMEOUT_EN is defined.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : forces the count back to zero
//   enable     : counts one per cycle while high
//   expired    : high while enabled and the count equals TIMEOUT_CYCLES-1
module sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    assign expired = enable && (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/aes_frame_sched.sv
// aes_frame_sched -- takes complete frames from an I2C slave, decodes the
// command, drives one operation on an AES-128 core and holds the result
// until the host acknowledges it.
// Optional build macro: FRAME_TIMEOUT_EN adds a WAIT-state timeout
// (sched_watchdog, TIMEOUT_CYCLES) reporting err=2'b11.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   rx_frame, rx_done         : frame {cmd, key, data} and its done level
//   aes_start, aes_decrypt    : start pulse and mode to the core
//   aes_key, aes_data         : operands, stable from start until done
//   aes_done, aes_result      : core completion pulse and output
//   result, result_valid      : latched result, valid until result_ack
//   result_ack                : host acknowledge
//   busy                      : high in any state except IDLE
//   err                       : sticky error code
module aes_frame_sched
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] rx_frame,
    input  logic               rx_done,
    output logic               aes_start,
    output logic               aes_decrypt,
    output logic [127:0]       aes_key,
    output logic [127:0]       aes_data,
    input  logic               aes_done,
    input  logic [127:0]       aes_result,
    output logic [127:0]       result,
    output logic               result_valid,
    input  logic               result_ack,
    output logic               busy,
    output logic [1:0]         err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("aes_frame_sched: TIMEOUT_CYCLES must be at least 2");
    end

    state_e       state_q, state_d;
    logic         rx_q;
    logic         start_q, start_d;
    logic         dec_q, dec_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] res_q, res_d;
    logic         rv_q, rv_d;
    logic [1:0]   err_q, err_d;
    logic [1:0]   err_set;
    logic         err_clr;
    logic         rx_rise;
    logic [7:0]   cmd;

    assign rx_rise = rx_done && !rx_q;
    assign cmd     = rx_frame[CMD_HI:CMD_LO];

`ifdef FRAME_TIMEOUT_EN
    logic wd_expired;

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != S_WAIT),
        .enable (state_q == S_WAIT),
        .expired(wd_expired)
    );
`endif

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        dec_d   = dec_q;
        key_d   = key_q;
        data_d  = data_q;
        res_d   = res_q;
        rv_d    = rv_q;
        err_set = ERR_NONE;
        err_clr = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rx_rise) err_set = err_max(err_set, ERR_OVERRUN);
                if (cmd == CMD_ENC || cmd == CMD_DEC) begin
                    dec_d   = (cmd == CMD_DEC);
                    key_d   = rx_frame[KEY_HI:KEY_LO];
                    data_d  = rx_frame[DATA_HI:DATA_LO];
                    start_d = 1'b1;
                    err_clr = 1'b1;
                    state_d = S_START;
                end else begin
                    err_set = err_max(err_set, ERR_CMD);
                    state_d = S_FAULT;
                end
            end
            S_START: begin
                if (rx_rise) err_set = err_max(err_set, ERR_OVERRUN);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rx_rise) err_set = err_max(err_set, ERR_OVERRUN);
                if (aes_done) begin
                    res_d   = aes_result;
                    rv_d    = 1'b1;
                    state_d = S_HOLD;
                end
`ifdef FRAME_TIMEOUT_EN
                else if (wd_expired) begin
                    err_set = err_max(err_set, ERR_TIMEOUT);
                    state_d = S_FAULT;
                end
`endif
            end
            S_HOLD: begin
                if (result_ack) begin
                    rv_d    = 1'b0;
                    state_d = rx_rise ? S_LOAD : S_IDLE;
                end else if (rx_rise) begin
                    err_set = err_max(err_set, ERR_OVERRUN);
                end
            end
            S_FAULT: begin
                // The edge that leaves FAULT is itself the next frame.
                rv_d = 1'b0;
                if (rx_rise) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        if (err_set != ERR_NONE) err_d = err_set;
        else if (err_clr)        err_d = ERR_NONE;
        else                     err_d = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rx_q    <= 1'b1;
            start_q <= 1'b0;
            dec_q   <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_done;
            start_q <= start_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            data_q  <= data_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign aes_start    = start_q;
    assign aes_decrypt  = dec_q;
    assign aes_key      = key_q;
    assign aes_data     = data_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_aes_frame_sched.sv
module tb_aes_frame_sched;

    logic         clk;
    logic         reset;
    logic [263:0] rx_frame;
    logic         rx_done;
    logic         aes_start;
    logic         aes_decrypt;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_done;
    logic [127:0] aes_result;
    logic [127:0] result;
    logic         result_valid;
    logic         result_ack;
    logic         busy;
    logic [1:0]   err;

    int unsigned total;
    int unsigned passed;
    int unsigned start_cnt;

    aes_frame_sched #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_frame    (rx_frame),
        .rx_done     (rx_done),
        .aes_start   (aes_start),
        .aes_decrypt (aes_decrypt),
        .aes_key     (aes_key),
        .aes_data    (aes_data),
        .aes_done    (aes_done),
        .aes_result  (aes_result),
        .result      (result),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (aes_start) start_cnt <= start_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]   cmd;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] res;
        logic         dec;
        logic         bad;
    } vec_t;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    // One complete frame; good commands run through to ack, bad ones end in FAULT.
    task automatic run_frame(input vec_t v);
        rx_frame = {v.cmd, v.key, v.data};
        rx_done  = 1'b1;
        tick();
        chk("start_not_early", aes_start, 0);
        chk("busy_in_load", busy, 1);
        tick();
        if (v.bad) begin
            chk("bad_no_start", aes_start, 0);
            chk("bad_err", err, 2'b01);
            rx_done = 1'b0;
            tick();
            chk("fault_busy", busy, 1);
            chk("fault_rv", result_valid, 0);
        end else begin
            chk("start_latency", aes_start, 1);
            chk("decrypt_mode", aes_decrypt, v.dec);
            chk("key_out", aes_key, v.key);
            chk("data_out", aes_data, v.data);
            chk("err_clear", err, 2'b00);
            rx_done = 1'b0;
            tick();
            chk("start_one_cycle", aes_start, 0);
            tick();
            tick();
            chk("no_early_valid", result_valid, 0);
            aes_done   = 1'b1;
            aes_result = v.res;
            tick();
            aes_done   = 1'b0;
            aes_result = '0;
            chk("rv_set", result_valid, 1);
            chk("result", result, v.res);
            tick();
            tick();
            chk("rv_held", result_valid, 1);
            chk("key_held", aes_key, v.key);
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            chk("rv_clear", result_valid, 0);
            chk("idle_after_ack", busy, 0);
        end
    endtask

    vec_t vecs[6];
    int unsigned sc;

    initial begin
        total = 0; passed = 0; start_cnt = 0;
        vecs[0] = '{cmd: 8'h01, key: K0, data: P0, res: C0, dec: 1'b0, bad: 1'b0};
        vecs[1] = '{cmd: 8'h02, key: K0, data: C0, res: P0, dec: 1'b1, bad: 1'b0};
        vecs[2] = '{cmd: 8'h7f, key: K0, data: P0, res: '0, dec: 1'b0, bad: 1'b1};
        vecs[3] = '{cmd: 8'h01, key: ~K0, data: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                    res: 128'hdead_beef_0000_1111_2222_3333_4444_5555, dec: 1'b0, bad: 1'b0};
        vecs[4] = '{cmd: 8'h00, key: K0, data: P0, res: '0, dec: 1'b0, bad: 1'b1};
        vecs[5] = '{cmd: 8'h02, key: 128'h1, data: 128'h2, res: 128'h3, dec: 1'b1, bad: 1'b0};

        // Reset with rx_done already high: the held level must not start a frame.
        reset = 1'b1; rx_frame = {8'h01, K0, P0}; rx_done = 1'b1;
        aes_done = 1'b0; aes_result = '0; result_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", aes_start, 0);
        chk("rst_key", aes_key, 0);
        chk("rst_data", aes_data, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_dec", aes_decrypt, 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_level_no_trigger", busy, 0);
        rx_done = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);
        chk("start_count_table", start_cnt, 4);

        // aes_done while idle is ignored.
        aes_done = 1'b1; aes_result = 128'hffff;
        tick();
        aes_done = 1'b0;
        chk("stray_done_rv", result_valid, 0);
        chk("stray_done_result", result, 128'h3);
        chk("stray_done_busy", busy, 0);

        // Overrun during WAIT.
        sc = start_cnt;
        rx_frame = {8'h01, K0, P0}; rx_done = 1'b1;
        tick(); tick();
        rx_done = 1'b0;
        tick(); tick();
        rx_frame = {8'h02, 128'haaaa, 128'hbbbb}; rx_done = 1'b1;
        tick();
        chk("ovr_err", err, 2'b10);
        chk("ovr_busy", busy, 1);
        chk("ovr_key_kept", aes_key, K0);
        chk("ovr_mode_kept", aes_decrypt, 0);
        tick();
        aes_done = 1'b1; aes_result = C0;
        tick();
        aes_done = 1'b0;
        chk("ovr_rv", result_valid, 1);
        chk("ovr_result", result, C0);
        chk("ovr_err_sticky", err, 2'b10);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        tick(); tick();
        chk("ovr_idle", busy, 0);
        chk("ovr_second_not_started", start_cnt - sc, 1);
        rx_done = 1'b0;
        tick();

        // Ack and new rx_done edge in the same HOLD cycle.
        rx_frame = {8'h01, K0, P0}; rx_done = 1'b1;
        tick(); tick();
        rx_done = 1'b0;
        tick();
        aes_done = 1'b1; aes_result = C0;
        tick();
        aes_done = 1'b0;
        chk("sim_rv", result_valid, 1);
        rx_frame = {8'h02, K0, C0}; rx_done = 1'b1; result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("sim_rv_clear", result_valid, 0);
        chk("sim_busy", busy, 1);
        chk("sim_no_start_yet", aes_start, 0);
        tick();
        chk("sim_start", aes_start, 1);
        chk("sim_dec", aes_decrypt, 1);
        chk("sim_data", aes_data, C0);
        chk("sim_err", err, 2'b00);
        rx_done = 1'b0;
        tick();
        aes_done = 1'b1; aes_result = P0;
        tick();
        aes_done = 1'b0;
        chk("sim_result", result, P0);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;

        // Timeout behaviour in WAIT with no aes_done.
        rx_frame = {8'h01, K0, P0}; rx_done = 1'b1;
        tick(); tick();
        chk("to_start", aes_start, 1);
        rx_done = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("to_not_yet", err, 2'b00);
        tick();
`ifdef FRAME_TIMEOUT_EN
        chk("to_err", err, 2'b11);
        chk("to_fault_busy", busy, 1);
        chk("to_fault_rv", result_valid, 0);
        run_frame(vecs[0]);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("no_to_err", err, 2'b00);
        chk("no_to_busy", busy, 1);
        aes_done = 1'b1; aes_result = C0;
        tick();
        aes_done = 1'b0;
        chk("no_to_result", result, C0);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
`endif

        // Reset during WAIT, then a late aes_done.
        rx_frame = {8'h02, K0, C0}; rx_done = 1'b1;
        tick(); tick();
        rx_done = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rstw_async_busy", busy, 0);
        chk("rstw_async_key", aes_key, 0);
        tick();
        reset = 1'b0;
        tick();
        aes_done = 1'b1; aes_result = P0;
        tick();
        aes_done = 1'b0;
        tick();
        chk("rstw_rv", result_valid, 0);
        chk("rstw_result", result, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_err", err, 0);
        chk("rstw_dec", aes_decrypt, 0);
        chk("rstw_data", aes_data, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
